irq_controller: RTL

- Parametrised, bus-attached interrupt controller. It replaces the single hard-wired keyboard `interrupt_vector` / `interrupt_done` path with NUM_SRC sources.
- Each source is configurable as edge- or level-sensitive and has its own enable mask.
- A fixed-priority encoder selects the winning source. Lowest index wins; source 0 is the keyboard.
- It drives one vectored request to the CPU, using a claim/complete handshake over the 64-bit system bus.

---
 rtl/irq_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Purpose : NUM_SRC-source interrupt controller with edge/level sources, enable masks,
//           a lowest-index-wins priority encoder and a claim/complete handshake on the 64-bit bus.
// Latency : source edge -> interrupt_req in 2 cycles; bus read data 1 cycle after the strobe.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports   : clk/reset (sync, active-high); irq_src (synchronised sources);
//           bus_sel/bus_address/bus_write_data/bus_write_enable/bus_read_enable -> bus_read_data/bus_read_valid;
//           interrupt_req/interrupt_vector to the CPU, interrupt_done back from it.
// Register map (bus_address[4:3]): 0 PENDING (W1C, edge bits), 1 ENABLE, 2 MODE (1=edge), 3 CLAIM.
module irq_controller #(
  parameter int                 NUM_SRC    = 8,
  parameter int                 VEC_W      = 6,
  parameter logic [NUM_SRC-1:0] MODE_RESET = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_sel,
  input  logic [4:0]         bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               bus_read_valid,
  output logic               interrupt_req,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_done
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_prev_src;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;
  logic [0:0]         r_state;
  logic [VEC_W-1:0]   r_in_service;
  // Low for the first cycle after reset: r_prev_src is cleared by reset, so a
  // source still held high would otherwise look like a fresh 0->1 edge.
  logic               r_armed;

  logic               w_rd;
  logic               w_wr;
  logic [1:0]         w_sel;
  logic [NUM_SRC-1:0] w_active;
  logic [VEC_W-1:0]   w_winner_id;
  logic [NUM_SRC-1:0] w_win_onehot;
  logic               w_claim;
  logic               w_complete;
  logic [NUM_SRC-1:0] w_edge_set;
  logic [NUM_SRC-1:0] w_edge_clr;
  logic [NUM_SRC-1:0] w_pending_next;
  logic [0:0]         w_next_state;
  logic [VEC_W-1:0]   w_next_in_service;
  logic [63:0]        w_rdata;
  logic               w_unused;

  assign w_rd     = bus_sel & bus_read_enable;
  assign w_wr     = bus_sel & bus_write_enable;
  assign w_sel    = bus_address[4:3];
  assign w_active = r_pending & r_enable;
  assign w_unused = ^{bus_address[2:0], bus_write_data};

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    w_winner_id  = '0;
    w_win_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_winner_id  = VEC_W'(i + 1);
        w_win_onehot = NUM_SRC'(1) << i;
      end
    end
  end

  assign w_claim    = w_rd && (w_sel == REG_CLAIM) && (r_state == S_IDLE) && (w_winner_id != '0);
  assign w_complete = (r_state == S_BUSY) &&
                      (interrupt_done ||
                       (w_wr && (w_sel == REG_CLAIM) && (bus_write_data[VEC_W-1:0] == r_in_service)));

  assign w_edge_set = irq_src & ~r_prev_src & {NUM_SRC{r_armed}};
  assign w_edge_clr = (w_claim ? w_win_onehot : {NUM_SRC{1'b0}}) |
                      ((w_wr && (w_sel == REG_PENDING)) ? bus_write_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}});

  // Edge bits: set beats clear. Level bits simply follow the source.
  assign w_pending_next = (r_mode & ((r_pending & ~w_edge_clr) | w_edge_set)) |
                          (~r_mode & irq_src);

  always_comb begin
    w_next_state      = r_state;
    w_next_in_service = r_in_service;
    if (w_claim) begin
      w_next_state      = S_BUSY;
      w_next_in_service = w_winner_id;
    end else if (w_complete) begin
      w_next_state      = S_IDLE;
      w_next_in_service = '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
      REG_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
      REG_MODE:    w_rdata[NUM_SRC-1:0] = r_mode;
      REG_CLAIM:   w_rdata[VEC_W-1:0]   = (r_state == S_BUSY) ? r_in_service : w_winner_id;
      default:     w_rdata              = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending        <= '0;
      r_prev_src       <= '0;
      r_enable         <= '0;
      r_mode           <= MODE_RESET;
      r_state          <= S_IDLE;
      r_in_service     <= '0;
      r_armed          <= 1'b0;
      interrupt_req    <= 1'b0;
      interrupt_vector <= '0;
      bus_read_data    <= '0;
      bus_read_valid   <= 1'b0;
    end else begin
      r_prev_src   <= irq_src;
      r_armed      <= 1'b1;
      r_pending    <= w_pending_next;
      r_state      <= w_next_state;
      r_in_service <= w_next_in_service;
      if (w_wr && (w_sel == REG_ENABLE)) begin
        r_enable <= bus_write_data[NUM_SRC-1:0];
      end
      if (w_wr && (w_sel == REG_MODE)) begin
        r_mode <= bus_write_data[NUM_SRC-1:0];
      end
      bus_read_valid <= w_rd;
      bus_read_data  <= w_rd ? w_rdata : 64'd0;
      // Outputs follow the state being entered, so a claim drops the request
      // in the same cycle the claim data returns.
      if (w_next_state == S_BUSY) begin
        interrupt_req    <= 1'b0;
        interrupt_vector <= w_next_in_service;
      end else begin
        interrupt_req    <= (w_winner_id != '0);
        interrupt_vector <= w_winner_id;
      end
    end
  end

endmodule
